// File: rtl/mux_tree_pkg.sv
// Shared types and elaboration helpers for the N:1 mux tree.
// Level k halves the element count of level k-1, rounding up.
package mux_tree_pkg;

  typedef struct packed {
    logic valid;
    logic err;
  } stage_ctl_t;

  function automatic int tree_levels(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // k = -1 gives the raw channel count feeding level 0
  function automatic int level_width(input int n, input int k);
    int w;
    w = n;
    for (int i = 0; i <= k; i++) begin
      w = (w + 1) / 2;
    end
    return w;
  endfunction

endpackage

// File: rtl/mux_nto1_pipe_if.sv
// Input/output handshake bundle for mux_nto1_pipe.
// The producer/consumer side uses master, the mux uses slave.
interface mux_nto1_pipe_if #(
  parameter int N = 3,
  parameter int W = 1
);
  localparam int SW = $clog2(N);

  logic [N*W-1:0] din;
  logic [SW-1:0]  sel;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   dout;
  logic           sel_err;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output din, sel, in_valid, out_ready,
    input  in_ready, dout, sel_err, out_valid
  );

  modport slave (
    input  din, sel, in_valid, out_ready,
    output in_ready, dout, sel_err, out_valid
  );

endinterface

// File: rtl/mux_nto1_pipe_mux2.sv
// W-bit 2:1 mux, one per element pair in each tree level.
// s_i = 1 selects the odd element.
module mux_2to1w #(
  parameter int W = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         s_i,
  output logic [W-1:0] y_o
);

  assign y_o = s_i ? b_i : a_i;

endmodule

// File: rtl/mux_nto1_pipe.sv
// N-input W-bit mux tree of 2:1 stages with optional per-level
// registers, valid/ready handshake and out-of-range select flag.
module mux_nto1_pipe
  import mux_tree_pkg::*;
#(
  parameter int N         = 3,
  parameter int W         = 1,
  parameter int REG_EVERY = 1,
  parameter int SW        = $clog2(N)
) (
  input logic            clk,
  input logic            reset,
  mux_nto1_pipe_if.slave bus
);

  localparam int L = tree_levels(N);

  logic stall;
  logic acc;

  assign stall        = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign acc          = bus.in_valid & ~stall;

  for (genvar k = 0; k < L; k++) begin : g_lv
    localparam int NI = level_width(N, k - 1);
    localparam int NO = level_width(N, k);
    localparam int SI = SW - k;

    logic [NI-1:0][W-1:0] i_data;
    logic [SI-1:0]        i_sel;
    stage_ctl_t           i_ctl;
    logic [NO-1:0][W-1:0] m_data;
    logic [NO-1:0][W-1:0] data_d;
    logic [NO-1:0][W-1:0] o_data;
    stage_ctl_t           o_ctl;

    if (k == 0) begin : g_src
      assign i_data = bus.din;
      assign i_sel  = bus.sel;
      // gating with acc keeps unknown din/sel out of the control bits
      assign i_ctl  = {acc, acc & (int'(bus.sel) >= N)};
    end else begin : g_nxt
      assign i_data = g_lv[k-1].o_data;
      assign i_sel  = g_lv[k-1].g_fwd.o_sel;
      assign i_ctl  = g_lv[k-1].o_ctl;
    end

    for (genvar e = 0; e < NO; e++) begin : g_el
      if (2 * e + 1 < NI) begin : g_pair
        mux_2to1w #(.W(W)) u_mux (
          .a_i (i_data[2*e]),
          .b_i (i_data[2*e+1]),
          .s_i (i_sel[0]),
          .y_o (m_data[e])
        );
      end else begin : g_odd
        assign m_data[e] = i_data[2*e];
      end
    end

    if (k == L - 1) begin : g_mask
      assign data_d = i_ctl.err ? '0 : m_data;
    end else begin : g_keep
      assign data_d = m_data;
    end

    if (REG_EVERY != 0 || k == L - 1) begin : g_reg
      logic [NO-1:0][W-1:0] data_q;
      stage_ctl_t           ctl_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_q <= '0;
          ctl_q  <= '0;
        end else if (!stall) begin
          data_q <= data_d;
          ctl_q  <= i_ctl;
        end
      end

      assign o_data = data_q;
      assign o_ctl  = ctl_q;
    end else begin : g_comb
      assign o_data = data_d;
      assign o_ctl  = i_ctl;
    end

    if (SI > 1) begin : g_fwd
      logic [SI-2:0] o_sel;

      if (REG_EVERY != 0) begin : g_r
        logic [SI-2:0] sel_q;

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            sel_q <= '0;
          end else if (!stall) begin
            sel_q <= i_sel[SI-1:1];
          end
        end

        assign o_sel = sel_q;
      end else begin : g_c
        assign o_sel = i_sel[SI-1:1];
      end
    end
  end

  assign bus.dout      = g_lv[L-1].o_data[0];
  assign bus.sel_err   = g_lv[L-1].o_ctl.err;
  assign bus.out_valid = g_lv[L-1].o_ctl.valid;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed and random checks of mux_nto1_pipe in three
// configurations: 3x1 and 5x8 fully pipelined, 8x4 single register.
module tb_mux_nto1_pipe;

  typedef struct {
    int         u;
    logic [39:0] din;
    logic [2:0]  sel;
    logic [7:0]  dout;
    logic        err;
    int          lat;
  } vec_t;

  localparam logic [39:0] DB = 40'h55_44_33_22_11;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  mux_nto1_pipe_if #(.N(3), .W(1)) ia ();
  mux_nto1_pipe_if #(.N(5), .W(8)) ib ();
  mux_nto1_pipe_if #(.N(8), .W(4)) ic ();

  mux_nto1_pipe #(.N(3), .W(1), .REG_EVERY(1)) u_a (
    .clk   (clk),
    .reset (rst),
    .bus   (ia.slave)
  );

  mux_nto1_pipe #(.N(5), .W(8), .REG_EVERY(1)) u_b (
    .clk   (clk),
    .reset (rst),
    .bus   (ib.slave)
  );

  mux_nto1_pipe #(.N(8), .W(4), .REG_EVERY(0)) u_c (
    .clk   (clk),
    .reset (rst),
    .bus   (ic.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic set_in(input int u, input logic [39:0] d,
                        input logic [2:0] s, input logic v);
    case (u)
      0: begin
        ia.din = d[2:0]; ia.sel = s[1:0]; ia.in_valid = v;
      end
      1: begin
        ib.din = d; ib.sel = s; ib.in_valid = v;
      end
      default: begin
        ic.din = d[31:0]; ic.sel = s; ic.in_valid = v;
      end
    endcase
  endtask

  // {out_valid, in_ready, sel_err, dout zero-extended to 8}
  function automatic logic [10:0] peek(input int u);
    case (u)
      0:       return {ia.out_valid, ia.in_ready, ia.sel_err, 7'd0, ia.dout};
      1:       return {ib.out_valid, ib.in_ready, ib.sel_err, ib.dout};
      default: return {ic.out_valid, ic.in_ready, ic.sel_err, 4'd0, ic.dout};
    endcase
  endfunction

  task automatic run_vec(input vec_t v, input int i);
    logic [10:0] o;
    int lat;
    o = peek(v.u);
    chk($sformatf("v%0d_in_ready", i), o[9], 1);
    set_in(v.u, v.din, v.sel, 1'b1);
    @(posedge clk); #1;
    set_in(v.u, v.din, v.sel, 1'b0);
    lat = 1;
    o = peek(v.u);
    while (!o[10] && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      o = peek(v.u);
    end
    chk($sformatf("v%0d_lat", i), lat, v.lat);
    chk($sformatf("v%0d_dout", i), o[7:0], v.dout);
    chk($sformatf("v%0d_err", i), o[8], v.err);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt [16];
    logic [10:0] o;
    logic [7:0]  q [$];
    logic [31:0] rd;
    logic [2:0]  rs;
    int nsent, nrecv, hold, extra, got, first, last;

    rst = 1'b1;
    ia.out_ready = 1'b1; ib.out_ready = 1'b1; ic.out_ready = 1'b1;
    for (int u = 0; u < 3; u++) set_in(u, 40'h0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("rst_state%0d", u), peek(u), 11'h200);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    vt[0]  = '{0, 40'h6, 3'd0, 8'h00, 1'b0, 2};
    vt[1]  = '{0, 40'h6, 3'd1, 8'h01, 1'b0, 2};
    vt[2]  = '{0, 40'h6, 3'd2, 8'h01, 1'b0, 2};
    vt[3]  = '{0, 40'h3, 3'd2, 8'h00, 1'b0, 2};
    vt[4]  = '{0, 40'h3, 3'd0, 8'h01, 1'b0, 2};
    vt[5]  = '{0, 40'h3, 3'd1, 8'h01, 1'b0, 2};
    vt[6]  = '{0, 40'h7, 3'd3, 8'h00, 1'b1, 2};
    vt[7]  = '{1, DB,    3'd4, 8'h55, 1'b0, 3};
    vt[8]  = '{1, DB,    3'd0, 8'h11, 1'b0, 3};
    vt[9]  = '{1, DB,    3'd3, 8'h44, 1'b0, 3};
    vt[10] = '{1, DB,    3'd6, 8'h00, 1'b1, 3};
    vt[11] = '{1, DB,    3'd5, 8'h00, 1'b1, 3};
    vt[12] = '{1, DB,    3'd7, 8'h00, 1'b1, 3};
    vt[13] = '{2, 40'h87654321, 3'd7, 8'h08, 1'b0, 1};
    vt[14] = '{2, 40'h87654321, 3'd0, 8'h01, 1'b0, 1};
    vt[15] = '{2, 40'h87654321, 3'd5, 8'h06, 1'b0, 1};
    for (int i = 0; i < 16; i++) run_vec(vt[i], i);

    // back-to-back at full rate
    got = 0; first = -1; last = -1;
    for (int c = 0; c < 12; c++) begin
      o = peek(1);
      if (o[10]) begin
        chk($sformatf("b2b_dout%0d", got), o[7:0], 8'h11 * (got + 1));
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (c < 5) begin
        chk($sformatf("b2b_in_ready%0d", c), o[9], 1);
        set_in(1, DB, 3'(c), 1'b1);
      end else begin
        set_in(1, DB, 3'd0, 1'b0);
      end
      @(posedge clk); #1;
    end
    chk("b2b_count", got, 5);
    chk("b2b_span", last - first, 4);

    // backpressure on the second result for 4 cycles
    nsent = 0; nrecv = 0; hold = 0; extra = 0;
    for (int c = 0; c < 40 && nrecv < 5; c++) begin
      ib.out_ready = !(ib.out_valid && nrecv == 1 && hold < 4);
      #1;
      o = peek(1);
      if (!ib.out_ready) begin
        chk("bp_in_ready", o[9], 0);
        chk("bp_dout_stable", o[7:0], 8'h22);
        hold++;
      end
      if (nsent < 5 && o[9]) begin
        set_in(1, DB, 3'(nsent), 1'b1);
        nsent++;
      end else begin
        set_in(1, DB, 3'd0, 1'b0);
      end
      if (o[10] && ib.out_ready) begin
        chk($sformatf("bp_order%0d", nrecv), o[7:0], 8'h11 * (nrecv + 1));
        nrecv++;
      end
      @(posedge clk); #1;
    end
    ib.out_ready = 1'b1;
    set_in(1, DB, 3'd0, 1'b0);
    repeat (6) begin
      @(posedge clk); #1;
      o = peek(1);
      if (o[10]) extra++;
    end
    chk("bp_recv", nrecv, 5);
    chk("bp_hold", hold, 4);
    chk("bp_extra", extra, 0);

    // asynchronous reset with two items in flight
    set_in(1, DB, 3'd1, 1'b1);
    @(posedge clk); #1;
    set_in(1, DB, 3'd2, 1'b1);
    @(posedge clk); #1;
    set_in(1, DB, 3'd0, 1'b0);
    @(posedge clk); #1;
    o = peek(1);
    chk("rst_pre_valid", o[10], 1);
    chk("rst_pre_dout", o[7:0], 8'h22);
    rst = 1'b1;
    #1;
    chk("rst_mid_state", peek(1), 11'h200);
    #2;
    rst = 1'b0;
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      o = peek(1);
      if (o[10]) extra++;
    end
    chk("rst_no_replay", extra, 0);
    run_vec('{1, DB, 3'd3, 8'h44, 1'b0, 3}, 99);

    // random traffic with random backpressure, single-register config
    nrecv = 0;
    q.delete();
    for (int c = 0; c < 5000 && nrecv < 1000; c++) begin
      ic.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      o = peek(2);
      if (o[10] && ic.out_ready) begin
        if (q.size() == 0) chk("rnd_underflow", 1, 0);
        else chk("rnd_dout", o[7:0], q.pop_front());
        nrecv++;
      end
      if ($urandom_range(0, 3) != 0) begin
        rd = $urandom();
        rs = 3'($urandom_range(0, 7));
        set_in(2, {8'h0, rd}, rs, 1'b1);
        if (o[9]) q.push_back({4'h0, rd[rs*4 +: 4]});
      end else begin
        set_in(2, 40'h0, 3'd0, 1'b0);
      end
      @(posedge clk); #1;
    end
    chk("rnd_count", nrecv, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
